// File: rtl/pipeline_stage_memory_access.sv
// Memory-access pipeline stage: passes ALU results through and runs loads/stores
// over a valid/ready data-memory handshake with lane steering and extension.
module pipeline_stage_memory_access #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  exValid,
   input  logic [31:0]           exInstruction,
   input  logic [3:0]            exMemOp,
   input  logic [ADDR_WIDTH-1:0] exAddress,
   input  logic [31:0]           exStoreData,
   input  logic [31:0]           exAluResult,
   input  logic [4:0]            exRegWriteId,
   input  logic                  exRegWriteEnabled,
   output logic                  stall,
   output logic                  memReq,
   output logic                  memWrite,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [3:0]            memByteEnable,
   output logic [31:0]           memWriteData,
   input  logic                  memReady,
   input  logic [31:0]           memReadData,
   output logic                  wbBubbled,
   output logic [31:0]           wbInstruction,
   output logic [4:0]            wbRegWriteId,
   output logic                  wbRegWriteEnabled,
   output logic [31:0]           wbRegDataWrite,
   output logic                  misaligned
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   state_t state, state_next;

   logic        ex_load;
   logic        ex_store;
   logic        ex_misaligned;
   logic [3:0]  ex_byte_enable;
   logic [31:0] ex_write_data;
   logic        start_access;

   logic [3:0]  req_op;
   logic [1:0]  req_offset;
   logic [4:0]  req_id;
   logic        req_enabled;
   logic [31:0] req_instruction;

   logic [31:0] byte_shifted;
   logic [31:0] half_shifted;
   logic [31:0] load_data;

   // Decode the incoming operation and pre-steer store lanes so the request
   // registers can be loaded directly at acceptance.
   always_comb begin
      ex_load        = 1'b0;
      ex_store       = 1'b0;
      ex_misaligned  = 1'b0;
      ex_byte_enable = 4'b0000;
      ex_write_data  = 32'h0;
      case (exMemOp)
         OP_LB, OP_LBU: ex_load = 1'b1;
         OP_LH, OP_LHU: begin
            ex_load       = 1'b1;
            ex_misaligned = exAddress[0];
         end
         OP_LW: begin
            ex_load       = 1'b1;
            ex_misaligned = |exAddress[1:0];
         end
         OP_SB: begin
            ex_store       = 1'b1;
            ex_byte_enable = 4'b0001 << exAddress[1:0];
            ex_write_data  = {4{exStoreData[7:0]}};
         end
         OP_SH: begin
            ex_store       = 1'b1;
            ex_misaligned  = exAddress[0];
            ex_byte_enable = exAddress[1] ? 4'b1100 : 4'b0011;
            ex_write_data  = {2{exStoreData[15:0]}};
         end
         OP_SW: begin
            ex_store       = 1'b1;
            ex_misaligned  = |exAddress[1:0];
            ex_byte_enable = 4'b1111;
            ex_write_data  = exStoreData;
         end
         default: ;
      endcase
   end

   assign start_access = (state == IDLE) && exValid && (ex_load || ex_store) && !ex_misaligned;
   assign stall        = (state == ACCESS);
   assign memReq       = (state == ACCESS);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_access) state_next = ACCESS;
         ACCESS:  if (memReady) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Select the addressed lane from the returned word using the latched offset.
   always_comb begin
      byte_shifted = memReadData >> {req_offset, 3'b000};
      half_shifted = memReadData >> {req_offset[1], 4'b0000};
      load_data    = 32'h0;
      case (req_op)
         OP_LB:   load_data = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
         OP_LBU:  load_data = {24'h0, byte_shifted[7:0]};
         OP_LH:   load_data = {{16{half_shifted[15]}}, half_shifted[15:0]};
         OP_LHU:  load_data = {16'h0, half_shifted[15:0]};
         OP_LW:   load_data = memReadData;
         default: load_data = 32'h0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         memWrite          <= 1'b0;
         memAddr           <= '0;
         memByteEnable     <= 4'b0000;
         memWriteData      <= 32'h0;
         req_op            <= 4'd0;
         req_offset        <= 2'd0;
         req_id            <= 5'd0;
         req_enabled       <= 1'b0;
         req_instruction   <= 32'h0;
         wbBubbled         <= 1'b1;
         wbInstruction     <= 32'h0;
         wbRegWriteId      <= 5'd0;
         wbRegWriteEnabled <= 1'b0;
         wbRegDataWrite    <= 32'h0;
         misaligned        <= 1'b0;
      end else if (state == IDLE) begin
         if (!exValid) begin
            wbBubbled         <= 1'b1;
            wbRegWriteEnabled <= 1'b0;
            misaligned        <= 1'b0;
         end else if (ex_misaligned) begin
            wbBubbled         <= 1'b0;
            wbInstruction     <= exInstruction;
            wbRegWriteId      <= exRegWriteId;
            wbRegWriteEnabled <= 1'b0;
            wbRegDataWrite    <= 32'h0;
            misaligned        <= 1'b1;
         end else if (ex_load || ex_store) begin
            memWrite          <= ex_store;
            memAddr           <= {exAddress[ADDR_WIDTH-1:2], 2'b00};
            memByteEnable     <= ex_byte_enable;
            memWriteData      <= ex_write_data;
            req_op            <= exMemOp;
            req_offset        <= exAddress[1:0];
            req_id            <= exRegWriteId;
            req_enabled       <= exRegWriteEnabled;
            req_instruction   <= exInstruction;
            wbBubbled         <= 1'b1;
            wbRegWriteEnabled <= 1'b0;
            misaligned        <= 1'b0;
         end else begin
            wbBubbled         <= 1'b0;
            wbInstruction     <= exInstruction;
            wbRegWriteId      <= exRegWriteId;
            wbRegWriteEnabled <= exRegWriteEnabled;
            wbRegDataWrite    <= exAluResult;
            misaligned        <= 1'b0;
         end
      end else begin
         // Request registers stay untouched while waiting so mem* remain stable.
         misaligned <= 1'b0;
         if (memReady) begin
            wbBubbled         <= 1'b0;
            wbInstruction     <= req_instruction;
            wbRegWriteId      <= req_id;
            wbRegWriteEnabled <= memWrite ? 1'b0 : req_enabled;
            wbRegDataWrite    <= memWrite ? 32'h0 : load_data;
         end else begin
            wbBubbled         <= 1'b1;
            wbRegWriteEnabled <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_stage_memory_access.sv
// Self-checking bench for the memory-access stage: directed scenarios followed by
// randomized operations checked against a transaction-level reference model.
module tb_pipeline_stage_memory_access;

   localparam int AW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          exValid;
   logic [31:0]   exInstruction;
   logic [3:0]    exMemOp;
   logic [AW-1:0] exAddress;
   logic [31:0]   exStoreData;
   logic [31:0]   exAluResult;
   logic [4:0]    exRegWriteId;
   logic          exRegWriteEnabled;
   logic          stall;
   logic          memReq;
   logic          memWrite;
   logic [AW-1:0] memAddr;
   logic [3:0]    memByteEnable;
   logic [31:0]   memWriteData;
   logic          memReady;
   logic [31:0]   memReadData;
   logic          wbBubbled;
   logic [31:0]   wbInstruction;
   logic [4:0]    wbRegWriteId;
   logic          wbRegWriteEnabled;
   logic [31:0]   wbRegDataWrite;
   logic          misaligned;

   int compared   = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   pipeline_stage_memory_access #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset),
      .exValid(exValid), .exInstruction(exInstruction), .exMemOp(exMemOp),
      .exAddress(exAddress), .exStoreData(exStoreData), .exAluResult(exAluResult),
      .exRegWriteId(exRegWriteId), .exRegWriteEnabled(exRegWriteEnabled),
      .stall(stall), .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
      .memByteEnable(memByteEnable), .memWriteData(memWriteData),
      .memReady(memReady), .memReadData(memReadData),
      .wbBubbled(wbBubbled), .wbInstruction(wbInstruction), .wbRegWriteId(wbRegWriteId),
      .wbRegWriteEnabled(wbRegWriteEnabled), .wbRegDataWrite(wbRegDataWrite),
      .misaligned(misaligned)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model: operation classes and results from the operation rules.
   function automatic bit isMemOp(input int op);
      return (op >= 1) && (op <= 8);
   endfunction

   function automatic bit isStoreOp(input int op);
      return (op >= 6) && (op <= 8);
   endfunction

   function automatic bit isMisaligned(input int op, input logic [31:0] addr);
      if ((op == 3 || op == 4 || op == 7) && (addr % 2 != 0)) return 1'b1;
      if ((op == 5 || op == 8) && (addr % 4 != 0)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] loadResult(input int op, input logic [31:0] addr, input logic [31:0] rdata);
      int L;
      logic [31:0] b, h;
      L = int'(addr % 4);
      b = (rdata >> (8 * L)) & 32'hFF;
      h = (rdata >> (16 * (L / 2))) & 32'hFFFF;
      case (op)
         1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         2: return b;
         3: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         4: return h;
         5: return rdata;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] storeEnable(input int op, input logic [31:0] addr);
      case (op)
         6: return 32'd1 << (addr % 4);
         7: return (addr % 4 >= 2) ? 32'd12 : 32'd3;
         8: return 32'd15;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] storeWord(input int op, input logic [31:0] d);
      case (op)
         6: return (d & 32'hFF) * 32'h0101_0101;
         7: return (d & 32'hFFFF) * 32'h0001_0001;
         8: return d;
         default: return 32'h0;
      endcase
   endfunction

   // Runs one whole operation from acceptance to its result; entered and left at a negedge.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] alu, input logic [4:0] id, input logic en,
                                input logic [31:0] instr, input int waits, input logic [31:0] rdata);
      logic [31:0] expData;
      logic        expEn;
      logic        expMis;
      exValid = 1'b1;
      exMemOp = op;
      exAddress = addr;
      exStoreData = sd;
      exAluResult = alu;
      exRegWriteId = id;
      exRegWriteEnabled = en;
      exInstruction = instr;
      memReady = 1'b0;
      memReadData = $urandom;
      checkOutput("stall_idle", {31'd0, stall}, 32'd0);
      @(posedge clock); @(negedge clock);
      exValid = 1'b0;
      exMemOp = 4'($urandom);
      if (isMemOp(int'(op)) && !isMisaligned(int'(op), addr)) begin
         for (int w = 0; w <= waits; w++) begin
            checkOutput("stall_access", {31'd0, stall}, 32'd1);
            checkOutput("memReq", {31'd0, memReq}, 32'd1);
            checkOutput("memAddr", memAddr, addr & 32'hFFFF_FFFC);
            checkOutput("memWrite", {31'd0, memWrite}, {31'd0, isStoreOp(int'(op))});
            checkOutput("memByteEnable", {28'd0, memByteEnable}, storeEnable(int'(op), addr));
            if (isStoreOp(int'(op))) checkOutput("memWriteData", memWriteData, storeWord(int'(op), sd));
            checkOutput("wbBubbled_wait", {31'd0, wbBubbled}, 32'd1);
            checkOutput("wbEn_wait", {31'd0, wbRegWriteEnabled}, 32'd0);
            memReady = (w == waits);
            memReadData = (w == waits) ? rdata : $urandom;
            @(posedge clock); @(negedge clock);
         end
         memReady = 1'b0;
         expMis  = 1'b0;
         expEn   = isStoreOp(int'(op)) ? 1'b0 : en;
         expData = isStoreOp(int'(op)) ? 32'h0 : loadResult(int'(op), addr, rdata);
      end else if (isMemOp(int'(op))) begin
         expMis = 1'b1; expEn = 1'b0; expData = 32'h0;
      end else begin
         expMis = 1'b0; expEn = en; expData = alu;
      end
      checkOutput("wbBubbled", {31'd0, wbBubbled}, 32'd0);
      checkOutput("wbRegWriteEnabled", {31'd0, wbRegWriteEnabled}, {31'd0, expEn});
      checkOutput("wbRegDataWrite", wbRegDataWrite, expData);
      checkOutput("wbRegWriteId", {27'd0, wbRegWriteId}, {27'd0, id});
      checkOutput("wbInstruction", wbInstruction, instr);
      checkOutput("misaligned", {31'd0, misaligned}, {31'd0, expMis});
      checkOutput("stall_result", {31'd0, stall}, 32'd0);
      checkOutput("memReq_result", {31'd0, memReq}, 32'd0);
   endtask

   // One cycle without a valid operation, optionally with a stray memReady.
   task automatic idleCycle(input logic strayReady);
      exValid = 1'b0;
      memReady = strayReady;
      @(posedge clock); @(negedge clock);
      memReady = 1'b0;
      checkOutput("idle_bubbled", {31'd0, wbBubbled}, 32'd1);
      checkOutput("idle_en", {31'd0, wbRegWriteEnabled}, 32'd0);
      checkOutput("idle_misaligned", {31'd0, misaligned}, 32'd0);
      checkOutput("idle_memReq", {31'd0, memReq}, 32'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] addr;
      reset = 1'b1;
      exValid = 1'b0;
      exInstruction = 32'h0;
      exMemOp = 4'd0;
      exAddress = '0;
      exStoreData = 32'h0;
      exAluResult = 32'h0;
      exRegWriteId = 5'd0;
      exRegWriteEnabled = 1'b0;
      memReady = 1'b0;
      memReadData = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      $display("[TB] reset values");
      checkOutput("rst_stall", {31'd0, stall}, 32'd0);
      checkOutput("rst_memReq", {31'd0, memReq}, 32'd0);
      checkOutput("rst_memWrite", {31'd0, memWrite}, 32'd0);
      checkOutput("rst_memAddr", memAddr, 32'd0);
      checkOutput("rst_memByteEnable", {28'd0, memByteEnable}, 32'd0);
      checkOutput("rst_memWriteData", memWriteData, 32'd0);
      checkOutput("rst_wbBubbled", {31'd0, wbBubbled}, 32'd1);
      checkOutput("rst_wbInstruction", wbInstruction, 32'd0);
      checkOutput("rst_wbRegWriteId", {27'd0, wbRegWriteId}, 32'd0);
      checkOutput("rst_wbRegWriteEnabled", {31'd0, wbRegWriteEnabled}, 32'd0);
      checkOutput("rst_wbRegDataWrite", wbRegDataWrite, 32'd0);
      checkOutput("rst_misaligned", {31'd0, misaligned}, 32'd0);

      $display("[TB] non-memory stream");
      applyStimulus(4'd0, 32'h0, 32'h0, 32'h11, 5'd1, 1'b1, 32'hA000_0001, 0, 32'h0);
      applyStimulus(4'd0, 32'h0, 32'h0, 32'h22, 5'd2, 1'b1, 32'hA000_0002, 0, 32'h0);
      applyStimulus(4'd0, 32'h0, 32'h0, 32'h33, 5'd3, 1'b1, 32'hA000_0003, 0, 32'h0);

      $display("[TB] byte loads with wait states");
      applyStimulus(4'd1, 32'h1003, 32'h0, 32'h0, 5'd4, 1'b1, 32'hB000_0001, 2, 32'h80FF_0102);
      checkOutput("lb_const", wbRegDataWrite, 32'hFFFF_FF80);
      applyStimulus(4'd2, 32'h1003, 32'h0, 32'h0, 5'd5, 1'b1, 32'hB000_0002, 2, 32'h80FF_0102);
      checkOutput("lbu_const", wbRegDataWrite, 32'h0000_0080);

      $display("[TB] halfword store");
      applyStimulus(4'd7, 32'h2002, 32'h1234_ABCD, 32'h0, 5'd6, 1'b1, 32'hB000_0003, 1, 32'h0);

      $display("[TB] misaligned word load");
      applyStimulus(4'd5, 32'h3002, 32'h0, 32'h0, 5'd7, 1'b1, 32'hB000_0004, 0, 32'h0);

      $display("[TB] reset during access");
      exValid = 1'b1;
      exMemOp = 4'd5;
      exAddress = 32'h4000;
      exRegWriteId = 5'd9;
      exRegWriteEnabled = 1'b1;
      exInstruction = 32'hC000_0001;
      @(posedge clock); @(negedge clock);
      exValid = 1'b0;
      checkOutput("rstacc_memReq1", {31'd0, memReq}, 32'd1);
      @(posedge clock); @(negedge clock);
      checkOutput("rstacc_memReq2", {31'd0, memReq}, 32'd1);
      reset = 1'b1;
      @(posedge clock); @(negedge clock);
      reset = 1'b0;
      checkOutput("rstacc_memReq", {31'd0, memReq}, 32'd0);
      checkOutput("rstacc_stall", {31'd0, stall}, 32'd0);
      checkOutput("rstacc_bubbled", {31'd0, wbBubbled}, 32'd1);
      checkOutput("rstacc_memAddr", memAddr, 32'd0);
      checkOutput("rstacc_data", wbRegDataWrite, 32'd0);
      memReadData = 32'hDEAD_BEEF;
      idleCycle(1'b1);
      checkOutput("rstacc_late_data", wbRegDataWrite, 32'd0);

      $display("[TB] halfword load with held follower");
      exValid = 1'b1;
      exMemOp = 4'd3;
      exAddress = 32'h5002;
      exRegWriteId = 5'd10;
      exRegWriteEnabled = 1'b1;
      exInstruction = 32'hC000_0002;
      @(posedge clock); @(negedge clock);
      checkOutput("held_stall", {31'd0, stall}, 32'd1);
      exMemOp = 4'd0;
      exAluResult = 32'h0000_CAFE;
      exRegWriteId = 5'd11;
      exInstruction = 32'hC000_0003;
      memReady = 1'b1;
      memReadData = 32'h8001_7FFF;
      @(posedge clock); @(negedge clock);
      memReady = 1'b0;
      checkOutput("held_lh_data", wbRegDataWrite, loadResult(3, 32'h5002, 32'h8001_7FFF));
      checkOutput("held_lh_const", wbRegDataWrite, 32'hFFFF_8001);
      checkOutput("held_lh_id", {27'd0, wbRegWriteId}, 32'd10);
      checkOutput("held_lh_bubbled", {31'd0, wbBubbled}, 32'd0);
      checkOutput("held_lh_stall", {31'd0, stall}, 32'd0);
      @(posedge clock); @(negedge clock);
      exValid = 1'b0;
      checkOutput("held_none_data", wbRegDataWrite, 32'h0000_CAFE);
      checkOutput("held_none_id", {27'd0, wbRegWriteId}, 32'd11);
      checkOutput("held_none_bubbled", {31'd0, wbBubbled}, 32'd0);
      checkOutput("held_none_instr", wbInstruction, 32'hC000_0003);

      $display("[TB] randomized operations");
      for (int i = 0; i < 120; i++) begin
         op = 4'($urandom_range(0, 15));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (op == 4'd3 || op == 4'd4 || op == 4'd7) addr[0] = 1'b0;
            else if (op == 4'd5 || op == 4'd8) addr[1:0] = 2'b00;
         end
         applyStimulus(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                       $urandom, $urandom_range(0, 3), $urandom);
         if ($urandom_range(0, 2) == 0) idleCycle(1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
